// File: rtl/ex_stage_pkg.sv
// Shared opcodes, result classes and bundle types for the execute stage.
// The iterative multiplier is built only when HILO_MULT_EN is defined.
package ex_stage_pkg;

  localparam logic [7:0] EXE_NOP_OP   = 8'b00000000;
  localparam logic [7:0] EXE_AND_OP   = 8'b00100100;
  localparam logic [7:0] EXE_OR_OP    = 8'b00100101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b00100110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b00100111;
  localparam logic [7:0] EXE_SLL_OP   = 8'b01111100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b00000010;
  localparam logic [7:0] EXE_SRA_OP   = 8'b00000011;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b00010000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b00010001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b00010010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b00010011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_MOVE  = 3'b011;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_e;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
  } ex_mem_t;

  function automatic logic [31:0] mag32(
    input logic [31:0] x,
    input logic        sgn
  );
    return (sgn && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/ex_stage_mult_iter.sv
// 32-step shift-add multiplier; signed operands run on magnitudes.
// done pulses on the final step, with product valid in that cycle.
module mult_iter
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  mul_state_e  state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic        neg_q, neg_d;
  logic [63:0] acc_step;

  assign acc_step = acc_q + (mplier_q[count_q]
                    ? ({32'd0, mcand_q} << count_q)
                    : 64'd0);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    busy     = 1'b0;
    done     = 1'b0;
    product  = neg_q ? (~acc_step + 64'd1) : acc_step;
    unique case (state_q)
      MUL_IDLE: begin
        if (start) begin
          busy     = 1'b1;
          mcand_d  = mag32(a, signed_op);
          mplier_d = mag32(b, signed_op);
          neg_d    = signed_op & (a[31] ^ b[31]);
          acc_d    = '0;
          count_d  = '0;
          state_d  = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        busy    = 1'b1;
        acc_d   = acc_step;
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          done    = 1'b1;
          state_d = MUL_DONE;
        end
      end
      MUL_DONE: state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MUL_IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: logic/shift/HI-LO moves, owns HI/LO, feeds EX/MEM.
// HILO_MULT_EN adds the iterative MULT/MULTU unit and its stall.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  output logic [4:0]  ex_wd_o,
  output logic        ex_wreg_o,
  output logic [31:0] ex_wdata_o,
  output logic [4:0]  mem_wd_o,
  output logic        mem_wreg_o,
  output logic [31:0] mem_wdata_o,
  output logic        stallreq_o
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  ex_mem_t     mem_q, mem_d;
  logic [31:0] result;
  logic        stall;
  logic        mul_done;
  logic [63:0] mul_prod;

`ifdef HILO_MULT_EN
  logic mul_start;
  logic mul_signed;

  assign mul_start  = (aluop_i == EXE_MULT_OP) ||
                      (aluop_i == EXE_MULTU_OP);
  assign mul_signed = (aluop_i == EXE_MULT_OP);

  mult_iter u_mult (
    .clk       (clk),
    .rst       (rst),
    .start     (mul_start),
    .signed_op (mul_signed),
    .a         (reg1_i),
    .b         (reg2_i),
    .busy      (stall),
    .done      (mul_done),
    .product   (mul_prod)
  );
`else
  assign stall    = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
`endif

  always_comb begin
    result = '0;
    unique case (1'b1)
      alusel_i == EXE_RES_LOGIC: begin
        case (aluop_i)
          EXE_OR_OP:  result = reg1_i | reg2_i;
          EXE_AND_OP: result = reg1_i & reg2_i;
          EXE_XOR_OP: result = reg1_i ^ reg2_i;
          EXE_NOR_OP: result = ~(reg1_i | reg2_i);
          default:    result = '0;
        endcase
      end
      alusel_i == EXE_RES_SHIFT: begin
        case (aluop_i)
          EXE_SLL_OP: result = reg2_i << reg1_i[4:0];
          EXE_SRL_OP: result = reg2_i >> reg1_i[4:0];
          EXE_SRA_OP:
            result = 32'($signed(reg2_i) >>> reg1_i[4:0]);
          default:    result = '0;
        endcase
      end
      alusel_i == EXE_RES_MOVE: begin
        case (aluop_i)
          EXE_MFHI_OP: result = hi_q;
          EXE_MFLO_OP: result = lo_q;
          default:     result = '0;
        endcase
      end
      default: result = '0;
    endcase
  end

  // Upstream is frozen while the multiplier runs, so no MTHI/MTLO can collide.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (mul_done) begin
      {hi_d, lo_d} = mul_prod;
    end else if (aluop_i == EXE_MTHI_OP) begin
      hi_d = reg1_i;
    end else if (aluop_i == EXE_MTLO_OP) begin
      lo_d = reg1_i;
    end
  end

  always_comb begin
    mem_d = '0;
    if (!stall) begin
      mem_d.wd    = wd_i;
      mem_d.wreg  = wreg_i;
      mem_d.wdata = result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      mem_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      mem_q <= mem_d;
    end
  end

  assign ex_wd_o     = wd_i;
  assign ex_wreg_o   = wreg_i & ~stall;
  assign ex_wdata_o  = result;
  assign mem_wd_o    = mem_q.wd;
  assign mem_wreg_o  = mem_q.wreg;
  assign mem_wdata_o = mem_q.wdata;
  assign stallreq_o  = stall;

endmodule
